// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Pipeline sequencing beside the EX stage of a five-stage core.
//               Converts taken branches, jumps, load-use hazards and data
//               memory wait requests into PC / pipeline-register load enables
//               and bubble-insert strobes. Keeps saturating branch, taken and
//               stall statistics counters for debug.
// Ports       : clk_i, reset_i            clock, synchronous active-high reset
//               control_hazard_i          branch taken (condition handler, EX)
//               branch_type_i[2:0]        EX branch type, 0 = not a branch
//               jump_ex_i                 JAL/JALR in EX
//               load_ex_i, ex_rd_i[4:0]   EX load flag and destination reg
//               id_rs1_i, id_rs2_i        ID source registers
//               id_use_rs1_i/_rs2_i       ID instruction reads that source
//               mem_busy_i                data memory not ready
//               cnt_clr_i                 clear statistics counters
//               pc_le_o, pc_sel_o         PC load enable / target select
//               ifid_le_o, idex_le_o,
//               exmem_le_o                pipeline register load enables
//               ifid_clr_o, idex_clr_o    bubble insert into IF/ID, ID/EX
//               branch_cnt_o, taken_cnt_o,
//               stall_cnt_o               statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             control_hazard_i,
  input  logic [2:0]       branch_type_i,
  input  logic             jump_ex_i,
  input  logic             load_ex_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             mem_busy_i,
  input  logic             cnt_clr_i,
  output logic             pc_le_o,
  output logic             pc_sel_o,
  output logic             ifid_le_o,
  output logic             idex_le_o,
  output logic             exmem_le_o,
  output logic             ifid_clr_o,
  output logic             idex_clr_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [3:0]       C_HOLD_INIT = 4'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic is_branch;
  logic branch_taken;
  logic redirect;
  logic load_use;
  logic active;
  logic stall_event;

  // A taken flag with branch_type 000 is noise from the condition handler.
  assign is_branch    = (branch_type_i != 3'b000);
  assign branch_taken = control_hazard_i & is_branch;
  assign redirect     = jump_ex_i | branch_taken;
  assign load_use     = load_ex_i & (ex_rd_i != 5'd0) &
                        ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                         (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  assign active       = (state_q != S_HOLD);
  // A load-use stall only really happens when no redirect overrides it.
  assign stall_event  = mem_busy_i | (load_use & ~redirect);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == C_CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_HOLD;
      hold_q       <= C_HOLD_INIT;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Next state and zero-latency pipeline controls.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    pc_le_o    = 1'b0;
    pc_sel_o   = 1'b0;
    ifid_le_o  = 1'b0;
    idex_le_o  = 1'b0;
    exmem_le_o = 1'b0;
    ifid_clr_o = 1'b0;
    idex_clr_o = 1'b0;

    case (state_q)
      S_HOLD: begin
        ifid_clr_o = 1'b1;
        idex_clr_o = 1'b1;
        if (hold_q == 4'd0) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end

      S_RUN, S_MEM_WAIT: begin
        if (mem_busy_i) begin
          // Everything frozen; an EX redirect is re-evaluated once MEM frees.
          state_d = S_MEM_WAIT;
        end else begin
          state_d = S_RUN;
          if (redirect) begin
            pc_le_o    = 1'b1;
            pc_sel_o   = 1'b1;
            ifid_le_o  = 1'b1;
            idex_le_o  = 1'b1;
            exmem_le_o = 1'b1;
            ifid_clr_o = 1'b1;
            idex_clr_o = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID; let the load advance and bubble behind it.
            idex_le_o  = 1'b1;
            idex_clr_o = 1'b1;
            exmem_le_o = 1'b1;
          end else begin
            pc_le_o    = 1'b1;
            ifid_le_o  = 1'b1;
            idex_le_o  = 1'b1;
            exmem_le_o = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_HOLD;
        hold_d  = C_HOLD_INIT;
      end
    endcase
  end

  // Statistics: branch/taken counted only when EX actually advances; stall
  // counted for every frozen memory cycle and every real load-use bubble.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (cnt_clr_i) begin
      branch_cnt_d = '0;
      taken_cnt_d  = '0;
      stall_cnt_d  = '0;
    end else if (active) begin
      if (!mem_busy_i && is_branch) begin
        branch_cnt_d = sat_inc(branch_cnt_q);
      end
      if (!mem_busy_i && branch_taken) begin
        taken_cnt_d = sat_inc(taken_cnt_q);
      end
      if (stall_event) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end
    end
  end

  assign branch_cnt_o = branch_cnt_q;
  assign taken_cnt_o  = taken_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Directed self-checking bench for pipeline_hazard_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  localparam int CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             control_hazard_i;
  logic [2:0]       branch_type_i;
  logic             jump_ex_i;
  logic             load_ex_i;
  logic [4:0]       ex_rd_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_use_rs1_i;
  logic             id_use_rs2_i;
  logic             mem_busy_i;
  logic             cnt_clr_i;
  logic             pc_le_o;
  logic             pc_sel_o;
  logic             ifid_le_o;
  logic             idex_le_o;
  logic             exmem_le_o;
  logic             ifid_clr_o;
  logic             idex_clr_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] taken_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_controller #(
    .HOLD_CYCLES (2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .control_hazard_i (control_hazard_i),
    .branch_type_i    (branch_type_i),
    .jump_ex_i        (jump_ex_i),
    .load_ex_i        (load_ex_i),
    .ex_rd_i          (ex_rd_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_use_rs1_i     (id_use_rs1_i),
    .id_use_rs2_i     (id_use_rs2_i),
    .mem_busy_i       (mem_busy_i),
    .cnt_clr_i        (cnt_clr_i),
    .pc_le_o          (pc_le_o),
    .pc_sel_o         (pc_sel_o),
    .ifid_le_o        (ifid_le_o),
    .idex_le_o        (idex_le_o),
    .exmem_le_o       (exmem_le_o),
    .ifid_clr_o       (ifid_clr_o),
    .idex_clr_o       (idex_clr_o),
    .branch_cnt_o     (branch_cnt_o),
    .taken_cnt_o      (taken_cnt_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed control word: {pc_le, pc_sel, ifid_le, idex_le, exmem_le, ifid_clr, idex_clr}
  function automatic logic [31:0] ctl();
    return {25'd0, pc_le_o, pc_sel_o, ifid_le_o, idex_le_o, exmem_le_o,
            ifid_clr_o, idex_clr_o};
  endfunction

  localparam logic [31:0] C_HOLD   = 32'b0000011;
  localparam logic [31:0] C_FREEZE = 32'b0000000;
  localparam logic [31:0] C_NORMAL = 32'b1011100;
  localparam logic [31:0] C_REDIR  = 32'b1111111;
  localparam logic [31:0] C_LDUSE  = 32'b0001101;

  // Advance past the next rising edge; inputs change afterwards.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    control_hazard_i = 1'b0; branch_type_i = 3'b000; jump_ex_i = 1'b0;
    load_ex_i = 1'b0; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0; mem_busy_i = 1'b0; cnt_clr_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    idle();

    // Reset for three cycles.
    repeat (3) tick();
    chk("reset_ctl", ctl(), C_HOLD);
    chk("reset_branch_cnt", 32'(branch_cnt_o), 32'd0);
    chk("reset_taken_cnt", 32'(taken_cnt_o), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);

    // Release: two frozen cycles, then running.
    reset_i = 1'b0;
    #1 chk("hold1_ctl", ctl(), C_HOLD);
    tick();
    chk("hold2_ctl", ctl(), C_HOLD);
    tick();
    chk("run_ctl", ctl(), C_NORMAL);

    // Taken branch in RUN.
    branch_type_i = 3'b010; control_hazard_i = 1'b1;
    #1 chk("br_taken_ctl", ctl(), C_REDIR);
    tick(); idle();
    #1 chk("br_branch_cnt", 32'(branch_cnt_o), 32'd1);
    chk("br_taken_cnt", 32'(taken_cnt_o), 32'd1);
    chk("after_br_ctl", ctl(), C_NORMAL);

    // Taken flag with no branch type is ignored.
    control_hazard_i = 1'b1;
    #1 chk("ch_nobranch_ctl", ctl(), C_NORMAL);
    tick(); idle();
    #1 chk("ch_nobranch_taken", 32'(taken_cnt_o), 32'd1);

    // Load-use on rs2.
    load_ex_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_use_rs2_i = 1'b1;
    #1 chk("lduse_ctl", ctl(), C_LDUSE);
    tick(); idle();
    #1 chk("lduse_stall_cnt", 32'(stall_cnt_o), 32'd1);
    chk("lduse_one_cycle", ctl(), C_NORMAL);

    // Load-use on rs1, unused source does not matter.
    load_ex_i = 1'b1; ex_rd_i = 5'd9; id_rs1_i = 5'd9; id_use_rs1_i = 1'b1;
    id_rs2_i = 5'd9; id_use_rs2_i = 1'b0;
    #1 chk("lduse_rs1_ctl", ctl(), C_LDUSE);
    tick(); idle();
    #1 chk("lduse_rs1_stall_cnt", 32'(stall_cnt_o), 32'd2);

    // Matching but unused source: no stall.
    load_ex_i = 1'b1; ex_rd_i = 5'd7; id_rs2_i = 5'd7; id_use_rs2_i = 1'b0;
    #1 chk("unused_src_ctl", ctl(), C_NORMAL);
    tick(); idle();

    // x0 destination never stalls.
    load_ex_i = 1'b1; ex_rd_i = 5'd0; id_rs2_i = 5'd0; id_use_rs2_i = 1'b1;
    #1 chk("x0_ctl", ctl(), C_NORMAL);
    tick(); idle();
    #1 chk("x0_stall_cnt", 32'(stall_cnt_o), 32'd2);

    // Load-use together with a jump: redirect wins, no stall counted.
    load_ex_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_use_rs2_i = 1'b1;
    jump_ex_i = 1'b1;
    #1 chk("jump_lduse_ctl", ctl(), C_REDIR);
    tick(); idle();
    #1 chk("jump_stall_cnt", 32'(stall_cnt_o), 32'd2);
    chk("jump_taken_cnt", 32'(taken_cnt_o), 32'd1);
    chk("jump_branch_cnt", 32'(branch_cnt_o), 32'd1);

    // Taken BNE frozen behind three memory wait cycles.
    branch_type_i = 3'b001; control_hazard_i = 1'b1; mem_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("memwait%0d_ctl", i), ctl(), C_FREEZE);
      tick();
    end
    mem_busy_i = 1'b0;
    #1 chk("memwait_stall_cnt", 32'(stall_cnt_o), 32'd5);
    chk("memwait_taken_hold", 32'(taken_cnt_o), 32'd1);
    chk("memwait_redir_ctl", ctl(), C_REDIR);
    tick(); idle();
    #1 chk("memwait_taken_cnt", 32'(taken_cnt_o), 32'd2);
    chk("memwait_branch_cnt", 32'(branch_cnt_o), 32'd2);
    chk("memwait_back_run", ctl(), C_NORMAL);

    // Reset in the middle of a memory wait.
    mem_busy_i = 1'b1;
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; idle();
    #1 chk("midreset_ctl", ctl(), C_HOLD);
    chk("midreset_stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("midreset_taken_cnt", 32'(taken_cnt_o), 32'd0);
    tick(); tick();
    chk("midreset_run_ctl", ctl(), C_NORMAL);

    // Drive taken_cnt up to 0xFFFE with back-to-back taken branches.
    branch_type_i = 3'b100; control_hazard_i = 1'b1;
    for (int i = 0; i < 16'hFFFE; i++) tick();
    chk("pre_sat_taken_cnt", 32'(taken_cnt_o), 32'h0000FFFE);
    repeat (3) tick();
    chk("sat_taken_cnt", 32'(taken_cnt_o), 32'h0000FFFF);
    chk("sat_branch_cnt", 32'(branch_cnt_o), 32'h0000FFFF);

    // Clear overrides a same-cycle increment.
    cnt_clr_i = 1'b1;
    #1 chk("clr_ctl", ctl(), C_REDIR);
    tick(); idle();
    #1 chk("clr_taken_cnt", 32'(taken_cnt_o), 32'd0);
    chk("clr_branch_cnt", 32'(branch_cnt_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
